// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide sequencer.
// Holds the funct3 op codes, the FSM state type and the op-class helper.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam int ITER_CNT_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } state_t;

    function automatic logic is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 datapath: one shift-add (multiply) or restoring-subtract (divide) step per step pulse.
// Accumulator is {hi, lo}: product for multiply, {remainder, quotient} for divide.
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 op_mul,
    input  logic [WIDTH-1:0]     mag_a,
    input  logic [WIDTH-1:0]     mag_b,
    output logic [2*WIDTH-1:0]   acc
);

    logic [WIDTH-1:0]   opnd;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     sub_diff;
    logic [2*WIDTH-1:0] acc_nxt;

    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        sub_diff = rem_sh - {1'b0, opnd};
        acc_nxt  = acc;
        if (op_mul) begin
            if (acc[0])
                acc_nxt = {add_sum, acc[WIDTH-1:1]};
            else
                acc_nxt = {1'b0, acc[2*WIDTH-1:1]};
        end else if (!sub_diff[WIDTH]) begin
            // No borrow: the shifted remainder covered the divisor.
            acc_nxt = {sub_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc  <= '0;
            opnd <= '0;
        end else if (load) begin
            opnd <= op_mul ? mag_a : mag_b;
            acc  <= {{WIDTH{1'b0}}, (op_mul ? mag_b : mag_a)};
        end else if (step) begin
            acc <= acc_nxt;
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multi-cycle sequencer: done follows start by WIDTH+2 edges (2 for div-by-zero/overflow).
// No backpressure: start is ignored while busy; flush aborts to IDLE without done.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [ITER_CNT_W-1:0] CNT_LAST = ITER_CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]      MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                state;
    logic [ITER_CNT_W-1:0] cnt;
    logic [2:0]            f3_q;
    logic [WIDTH-1:0]      op_a;
    logic [WIDTH-1:0]      op_b;
    logic                  neg_q;
    logic                  neg_r;
    logic                  sp_dz;
    logic                  sp_ov;

    logic                  a_signed;
    logic                  b_signed;
    logic                  sa;
    logic                  sb;
    logic [WIDTH-1:0]      mag_a;
    logic [WIDTH-1:0]      mag_b;
    logic                  dz_det;
    logic                  ov_det;
    logic [2*WIDTH-1:0]    acc;
    logic [2*WIDTH-1:0]    prod;
    logic [WIDTH-1:0]      quo;
    logic [WIDTH-1:0]      rem;
    logic [WIDTH-1:0]      fix_val;

    always_comb begin
        a_signed = (f3_q != F3_MULHU) && (f3_q != F3_DIVU) && (f3_q != F3_REMU);
        b_signed = a_signed && (f3_q != F3_MULHSU);
        sa       = a_signed && op_a[WIDTH-1];
        sb       = b_signed && op_b[WIDTH-1];
        mag_a    = sa ? -op_a : op_a;
        mag_b    = sb ? -op_b : op_b;
        dz_det   = is_div(f3_q) && (op_b == '0);
        ov_det   = ((f3_q == F3_DIV) || (f3_q == F3_REM)) && (op_a == MIN_NEG) && (op_b == '1);
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .load   (state == PREP),
        .step   ((state == CALC) && !flush),
        .op_mul (!is_div(f3_q)),
        .mag_a  (mag_a),
        .mag_b  (mag_b),
        .acc    (acc)
    );

    always_comb begin
        prod    = neg_q ? -acc : acc;
        quo     = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem     = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fix_val = '0;
        // Corner cases bypass the iteration and take fixed RISC-V results.
        if (sp_dz) begin
            quo = '1;
            rem = op_a;
        end else if (sp_ov) begin
            quo = MIN_NEG;
            rem = '0;
        end
        case (f3_q)
            F3_MUL:                      fix_val = prod[WIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_val = prod[2*WIDTH-1:WIDTH];
            F3_DIV, F3_DIVU:             fix_val = quo;
            default:                     fix_val = rem;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cnt    <= '0;
            f3_q   <= '0;
            op_a   <= '0;
            op_b   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            sp_dz  <= 1'b0;
            sp_ov  <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= PREP;
                        busy  <= 1'b1;
                        f3_q  <= funct3;
                        op_a  <= a;
                        op_b  <= b;
                    end else begin
                        state <= IDLE;
                    end
                end
                PREP: begin
                    neg_q <= sa ^ sb;
                    neg_r <= sa;
                    sp_dz <= dz_det;
                    sp_ov <= ov_det;
                    cnt   <= '0;
                    state <= (dz_det || ov_det) ? FIX : CALC;
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST)
                        state <= FIX;
                end
                FIX: begin
                    result <= fix_val;
                    state  <= DONE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: arithmetic model plus per-cycle compare of busy/done/result.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          n_checks;
    int          n_errors;
    int          cyc;
    int          e0;
    int          lat;
    logic        pend;
    logic        cmp_en;
    logic [31:0] exp_res;
    logic [31:0] cur_res;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, expv);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] x,
                                          input logic [31:0] y);
        longint     sx, sy, uy;
        logic [63:0] p;
        logic       ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        uy  = longint'(y);
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        case (f3)
            F3_MUL:    begin p = 64'(sx * sy); return p[31:0]; end
            F3_MULH:   begin p = 64'(sx * sy); return p[63:32]; end
            F3_MULHSU: begin p = 64'(sx * uy); return p[63:32]; end
            F3_MULHU:  begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
            F3_DIV: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = 64'(sx / sy);
                return p[31:0];
            end
            F3_DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
            F3_REM: begin
                if (y == 0) return x;
                if (ovf) return 32'h0;
                p = 64'(sx % sy);
                return p[31:0];
            end
            default:   return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f3, input logic [31:0] x,
                                     input logic [31:0] y);
        if (f3[2] && y == 0) return 2;
        if ((f3 == F3_DIV || f3 == F3_REM) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
            return 2;
        return 34;
    endfunction

    // Every meaningful cycle: busy window, done pulse and held result follow the model.
    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            logic exp_busy;
            logic exp_done;
            exp_busy = pend && (cyc >= e0) && (cyc < e0 + lat);
            exp_done = pend && (cyc == e0 + lat);
            chk("busy", {31'b0, busy}, {31'b0, exp_busy});
            chk("done", {31'b0, done}, {31'b0, exp_done});
            if (exp_done) begin
                cur_res = exp_res;
                pend    = 1'b0;
            end
            chk("result", result, cur_res);
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the sampling edge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
        funct3 = f3;
        a      = x;
        b      = y;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        funct3  = 3'($urandom);
        a       = $urandom;
        b       = $urandom;
        e0      = cyc;
        lat     = model_lat(f3, x, y);
        exp_res = model(f3, x, y);
        pend    = 1'b1;
    endtask

    task automatic wait_done(input int lat_lit, input string nm);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 80) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (done !== 1'b1)
            chk({nm, "_timeout"}, {31'b0, done}, 32'd1);
        chk({nm, "_lat"}, cyc - e0, lat_lit);
    endtask

    task automatic run(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y,
                       input int lat_lit, input logic [31:0] res_lit, input string nm);
        issue(f3, x, y);
        wait_done(lat_lit, nm);
        chk(nm, result, res_lit);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] x;
        logic [31:0] y;
    } vec_t;

    vec_t extra [6];

    initial begin
        n_checks = 0;
        n_errors = 0;
        pend     = 1'b0;
        cmp_en   = 1'b0;
        cur_res  = '0;
        exp_res  = '0;
        e0       = 0;
        lat      = 0;
        reset    = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        funct3   = '0;
        a        = '0;
        b        = '0;
        extra[0] = '{F3_MUL,    32'hFFFF_FFF9, 32'hFFFF_FFFD};
        extra[1] = '{F3_DIV,    32'h7FFF_FFFF, 32'hFFFF_FFFD};
        extra[2] = '{F3_REM,    32'h0000_0007, 32'hFFFF_FFFE};
        extra[3] = '{F3_REMU,   32'hDEAD_BEEF, 32'h0000_1234};
        extra[4] = '{F3_MULHSU, 32'h1234_5678, 32'h8765_4321};
        extra[5] = '{F3_DIVU,   32'h8000_0000, 32'h0000_0000};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;

        run(F3_MUL,    32'd7,          32'd6,          34, 32'd42,         "mul");
        run(F3_MULH,   32'hFFFF_FFFE,  32'd3,          34, 32'hFFFF_FFFF,  "mulh");
        run(F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  34, 32'hFFFF_FFFE,  "mulhu");
        run(F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  34, 32'hFFFF_FFFF,  "mulhsu");
        run(F3_DIV,    32'hFFFF_FFF9,  32'd2,          34, 32'hFFFF_FFFD,  "div");
        run(F3_REM,    32'hFFFF_FFF9,  32'd2,          34, 32'hFFFF_FFFF,  "rem");
        run(F3_DIV,    32'd5,          32'd0,          2,  32'hFFFF_FFFF,  "div_by0");
        run(F3_REM,    32'd5,          32'd0,          2,  32'd5,          "rem_by0");
        run(F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  2,  32'h8000_0000,  "div_ovf");
        run(F3_REM,    32'h8000_0000,  32'hFFFF_FFFF,  2,  32'd0,          "rem_ovf");
        run(F3_REMU,   32'd9,          32'd0,          2,  32'd9,          "remu_by0");
        run(F3_DIVU,   32'd100,        32'd7,          34, 32'd14,         "divu");

        // Flush mid-CALC: sampled at E0+10, no done, result keeps 14.
        issue(F3_MUL, 32'd3, 32'd5);
        while (cyc < e0 + 9) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        pend  = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        chk("flush_hold", result, 32'd14);
        chk("flush_idle", {31'b0, busy}, 32'd0);

        // Flush wins over a simultaneous start.
        funct3 = F3_MUL;
        a      = 32'd1;
        b      = 32'd1;
        start  = 1'b1;
        flush  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("flush_prio", {31'b0, busy}, 32'd0);

        // Start while busy is dropped.
        issue(F3_MUL, 32'd9, 32'd9);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        funct3 = F3_DIV;
        a      = 32'd5;
        b      = 32'd0;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(34, "ignored_start");
        chk("ignored_start", result, 32'd81);
        @(posedge clk);
        #1;

        // Back-to-back accept in the DONE cycle.
        issue(F3_DIVU, 32'd1000, 32'd10);
        wait_done(34, "b2b_first");
        chk("b2b_first", result, 32'd100);
        issue(F3_MUL, 32'd12, 32'd12);
        wait_done(34, "b2b_second");
        chk("b2b_second", result, 32'd144);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-operation.
        issue(F3_MULHU, 32'hCAFE_F00D, 32'h1234_5678);
        while (cyc < e0 + 20) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        chk("arst_result", result, 32'd0);
        pend    = 1'b0;
        cur_res = '0;
        @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk);
        #1;
        run(F3_DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD, "after_rst");

        foreach (extra[i]) begin
            issue(extra[i].f3, extra[i].x, extra[i].y);
            wait_done(model_lat(extra[i].f3, extra[i].x, extra[i].y), "extra");
            @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
